// File: rtl/frv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// frv_mem_arbiter
//
// Merges the core's instruction (imem) and data (dmem) request/response
// channels onto one shared memory bus. A tag FIFO records which requester
// was granted, so responses are routed back in grant order.
//
// Optional feature macro: FRV_MEMARB_RR_EN
//   defined   : on contention, grant the source that was not granted last
//               (round-robin alternation)
//   undefined : on contention, dmem always wins
//
// Parameters:
//   OUTSTANDING  max accepted-but-unanswered transactions (1..4)
//
// Ports:
//   g_clk, g_resetn            clock, synchronous active-low reset
//   imem_* / dmem_*            requester channels: req/wen/strb/wdata/addr in,
//                              gnt out; recv/error/rdata out, ack in
//   mem_*                      shared bus: req/wen/strb/wdata/addr out,
//                              gnt in; recv/error/rdata in, ack out
// -----------------------------------------------------------------------------
// Arbiter state
//   state    | meaning
//   ST_OPEN  | free to select per request pattern
//   ST_HELD  | bus request pending without grant; selection pinned to
//            | lock_src_q so request fields stay stable until granted
// -----------------------------------------------------------------------------
module frv_mem_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        imem_req,
    input  logic        imem_wen,
    input  logic [3:0]  imem_strb,
    input  logic [31:0] imem_wdata,
    input  logic [31:0] imem_addr,
    output logic        imem_gnt,
    output logic        imem_recv,
    input  logic        imem_ack,
    output logic        imem_error,
    output logic [31:0] imem_rdata,

    input  logic        dmem_req,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_addr,
    output logic        dmem_gnt,
    output logic        dmem_recv,
    input  logic        dmem_ack,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,

    output logic        mem_req,
    output logic        mem_wen,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_recv,
    output logic        mem_ack,
    input  logic        mem_error,
    input  logic [31:0] mem_rdata
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(OUTSTANDING - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(OUTSTANDING);

    typedef enum logic {SRC_IMEM = 1'b0, SRC_DMEM = 1'b1} src_e;
    typedef enum logic {ST_OPEN = 1'b0, ST_HELD = 1'b1} state_e;

    state_e                 state_q, state_d;
    src_e                   lock_src_q, lock_src_d;
    logic [OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
`ifdef FRV_MEMARB_RR_EN
    src_e                   last_q, last_d;
`endif

    src_e sel;
    src_e head;
    logic sel_req;
    logic issue_en;
    logic has_tag;
    logic push;
    logic pop;

    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
`ifdef FRV_MEMARB_RR_EN
        last_d     = last_q;
`endif

        imem_gnt   = 1'b0;
        imem_recv  = 1'b0;
        imem_error = 1'b0;
        imem_rdata = '0;
        dmem_gnt   = 1'b0;
        dmem_recv  = 1'b0;
        dmem_error = 1'b0;
        dmem_rdata = '0;
        mem_req    = 1'b0;
        mem_wen    = 1'b0;
        mem_strb   = '0;
        mem_wdata  = '0;
        mem_addr   = '0;
        mem_ack    = 1'b0;

        // Source selection: pinned while held, else the lone requester, else
        // the contention policy.
        if (state_q == ST_HELD) begin
            sel = lock_src_q;
        end else if (imem_req != dmem_req) begin
            sel = dmem_req ? SRC_DMEM : SRC_IMEM;
        end else begin
`ifdef FRV_MEMARB_RR_EN
            sel = (last_q == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
`else
            sel = SRC_DMEM;
`endif
        end

        sel_req  = (sel == SRC_DMEM) ? dmem_req : imem_req;
        // Full FIFO blocks issue even if a pop lands in the same cycle.
        issue_en = (count_q < CNT_MAX);
        has_tag  = (count_q != '0);
        head     = fifo_q[rd_ptr_q] ? SRC_DMEM : SRC_IMEM;

        if (g_resetn) begin
            mem_req = issue_en && sel_req;
            if (sel == SRC_DMEM) begin
                mem_wen   = dmem_wen;
                mem_strb  = dmem_strb;
                mem_wdata = dmem_wdata;
                mem_addr  = dmem_addr;
                dmem_gnt  = mem_req && mem_gnt;
            end else begin
                mem_wen   = imem_wen;
                mem_strb  = imem_strb;
                mem_wdata = imem_wdata;
                mem_addr  = imem_addr;
                imem_gnt  = mem_req && mem_gnt;
            end

            if (has_tag) begin
                if (head == SRC_DMEM) begin
                    dmem_recv  = mem_recv;
                    dmem_error = mem_error;
                    dmem_rdata = mem_rdata;
                    mem_ack    = dmem_ack;
                end else begin
                    imem_recv  = mem_recv;
                    imem_error = mem_error;
                    imem_rdata = mem_rdata;
                    mem_ack    = imem_ack;
                end
            end else begin
                // Response with nothing outstanding: swallow it.
                mem_ack = mem_recv;
            end
        end

        push = mem_req && mem_gnt;
        pop  = has_tag && mem_recv && mem_ack;

        if (mem_gnt) begin
            state_d = ST_OPEN;
        end else if (mem_req) begin
            state_d    = ST_HELD;
            lock_src_d = sel;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = (sel == SRC_DMEM);
            wr_ptr_d         = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
`ifdef FRV_MEMARB_RR_EN
            last_d           = sel;
`endif
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q    <= ST_OPEN;
            lock_src_q <= SRC_IMEM;
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef FRV_MEMARB_RR_EN
            last_q     <= SRC_IMEM;
`endif
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef FRV_MEMARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
module tb_frv_mem_arbiter;

    localparam int OUTSTANDING = 2;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        imem_req, imem_wen, imem_gnt, imem_recv, imem_ack, imem_error;
    logic [3:0]  imem_strb;
    logic [31:0] imem_wdata, imem_addr, imem_rdata;
    logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_ack, dmem_error;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_wdata, dmem_addr, dmem_rdata;
    logic        mem_req, mem_wen, mem_gnt, mem_recv, mem_ack, mem_error;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata, mem_addr, mem_rdata;

    frv_mem_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
        .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
        .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
        .dmem_rdata(dmem_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error),
        .mem_rdata(mem_rdata)
    );

    always #5 g_clk = ~g_clk;

    typedef struct packed {
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] addr;
    } txn_t;

    typedef struct packed {
        logic        src;     // 0 = imem, 1 = dmem
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    // requester / bus stimulus state
    txn_t txn [2];
    bit   pend [2];
    bit   granted [2];
    rsp_t bus_q [$];
    bit   presenting;
    bit   spur;
    bit   want_spur;
    bit   resp_done;
    int   p_req [2];
    int   p_gnt, p_recv, p_ack;

    // reference model: outstanding responses in grant order
    rsp_t exp_q [$];
    bit   held, held_src, last_src;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit   m_sel, m_mreq, m_dest, m_ack, m_gi, m_gd;
    rsp_t m_r;

    always @(negedge g_clk) begin
        if (!g_resetn) begin
            chk("rst_mem_req", mem_req, 0);
            chk("rst_imem_gnt", imem_gnt, 0);
            chk("rst_dmem_gnt", dmem_gnt, 0);
            chk("rst_imem_recv", imem_recv, 0);
            chk("rst_dmem_recv", dmem_recv, 0);
            chk("rst_imem_rdata", imem_rdata, 0);
            chk("rst_dmem_rdata", dmem_rdata, 0);
            chk("rst_imem_error", imem_error, 0);
            chk("rst_dmem_error", dmem_error, 0);
            chk("rst_mem_ack", mem_ack, 0);
            chk("rst_mem_addr", mem_addr, 0);
            exp_q.delete();
            held       = 0;
            last_src   = 0;
            granted[0] = 0;
            granted[1] = 0;
            resp_done  = 0;
        end else begin
            // which source the rules pick this cycle
            if (held) m_sel = held_src;
            else if (imem_req != dmem_req) m_sel = dmem_req;
            else begin
`ifdef FRV_MEMARB_RR_EN
                m_sel = !last_src;
`else
                m_sel = 1'b1;
`endif
            end
            m_mreq = (exp_q.size() < OUTSTANDING) && (m_sel ? dmem_req : imem_req);
            chk("mem_req", mem_req, m_mreq);
            if (m_mreq) begin
                chk("mem_addr", mem_addr, txn[m_sel].addr);
                chk("mem_wdata", mem_wdata, txn[m_sel].wdata);
                chk("mem_wen", mem_wen, txn[m_sel].wen);
                chk("mem_strb", mem_strb, txn[m_sel].strb);
            end
            m_gi = m_mreq && mem_gnt && !m_sel;
            m_gd = m_mreq && mem_gnt && m_sel;
            chk("imem_gnt", imem_gnt, m_gi);
            chk("dmem_gnt", dmem_gnt, m_gd);
            granted[0] = m_gi;
            granted[1] = m_gd;
            if (mem_gnt) held = 0;
            else if (m_mreq) begin
                held     = 1;
                held_src = m_sel;
            end

            resp_done = 0;
            if (mem_recv) begin
                if (exp_q.size() == 0) begin
                    chk("spur_mem_ack", mem_ack, 1);
                    chk("spur_imem_recv", imem_recv, 0);
                    chk("spur_dmem_recv", dmem_recv, 0);
                    chk("spur_imem_rdata", imem_rdata, 0);
                    chk("spur_dmem_rdata", dmem_rdata, 0);
                    chk("spur_imem_error", imem_error, 0);
                    chk("spur_dmem_error", dmem_error, 0);
                    resp_done = 1;
                end else begin
                    m_dest = exp_q[0].src;
                    m_ack  = m_dest ? dmem_ack : imem_ack;
                    chk("mem_ack", mem_ack, m_ack);
                    chk("imem_recv", imem_recv, !m_dest);
                    chk("dmem_recv", dmem_recv, m_dest);
                    if (m_dest) begin
                        chk("dmem_rdata", dmem_rdata, exp_q[0].rdata);
                        chk("dmem_error", dmem_error, exp_q[0].err);
                        chk("imem_rdata_idle", imem_rdata, 0);
                        chk("imem_error_idle", imem_error, 0);
                    end else begin
                        chk("imem_rdata", imem_rdata, exp_q[0].rdata);
                        chk("imem_error", imem_error, exp_q[0].err);
                        chk("dmem_rdata_idle", dmem_rdata, 0);
                        chk("dmem_error_idle", dmem_error, 0);
                    end
                    if (m_ack) begin
                        void'(exp_q.pop_front());
                        resp_done = 1;
                    end
                end
            end else begin
                chk("imem_recv_idle", imem_recv, 0);
                chk("dmem_recv_idle", dmem_recv, 0);
            end

            if (m_gi || m_gd) begin
                last_src = m_sel;
                m_r.src   = m_sel;
                m_r.rdata = $urandom;
                m_r.err   = ($urandom_range(0, 3) == 0);
                exp_q.push_back(m_r);
                bus_q.push_back(m_r);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic new_txn(input int s);
        txn[s].addr  = $urandom;
        txn[s].wdata = $urandom;
        txn[s].wen   = 1'($urandom_range(0, 1));
        txn[s].strb  = 4'($urandom_range(0, 15));
        pend[s]      = 1;
    endtask

    task automatic apply_reqs();
        imem_req   = pend[0];
        imem_addr  = txn[0].addr;
        imem_wdata = txn[0].wdata;
        imem_wen   = txn[0].wen;
        imem_strb  = txn[0].strb;
        dmem_req   = pend[1];
        dmem_addr  = txn[1].addr;
        dmem_wdata = txn[1].wdata;
        dmem_wen   = txn[1].wen;
        dmem_strb  = txn[1].strb;
    endtask

    task automatic drive_cycle();
        for (int s = 0; s < 2; s++) begin
            if (granted[s]) begin
                pend[s]    = 0;
                granted[s] = 0;
            end
        end
        if (resp_done) begin
            if (spur) spur = 0;
            else begin
                void'(bus_q.pop_front());
                presenting = 0;
            end
            resp_done = 0;
        end
        for (int s = 0; s < 2; s++)
            if (!pend[s] && ($urandom_range(0, 99) < p_req[s])) new_txn(s);
        apply_reqs();
        mem_gnt = ($urandom_range(0, 99) < p_gnt);
        if (want_spur && !presenting && !spur && bus_q.size() == 0) begin
            spur      = 1;
            want_spur = 0;
        end
        if (!presenting && !spur && bus_q.size() > 0 && ($urandom_range(0, 99) < p_recv))
            presenting = 1;
        mem_recv  = presenting || spur;
        mem_rdata = presenting ? bus_q[0].rdata : $urandom;
        mem_error = presenting ? bus_q[0].err : 1'($urandom_range(0, 1));
        imem_ack  = ($urandom_range(0, 99) < p_ack);
        dmem_ack  = ($urandom_range(0, 99) < p_ack);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive_cycle();
            @(posedge g_clk);
            #1;
        end
    endtask

    task automatic set_p(input int ri, input int rd, input int g, input int rc, input int a);
        p_req[0] = ri;
        p_req[1] = rd;
        p_gnt    = g;
        p_recv   = rc;
        p_ack    = a;
    endtask

    task automatic do_reset(input int cycles);
        g_resetn   = 0;
        bus_q.delete();
        presenting = 0;
        spur       = 0;
        want_spur  = 0;
        for (int s = 0; s < 2; s++) if (!pend[s]) new_txn(s);
        apply_reqs();
        mem_gnt   = 1;
        mem_recv  = 1;
        mem_error = 1;
        mem_rdata = $urandom;
        imem_ack  = 1;
        dmem_ack  = 1;
        repeat (cycles) @(posedge g_clk);
        #1;
        g_resetn = 1;
    endtask

    initial begin
        pend[0] = 0;
        pend[1] = 0;
        txn[0]  = '0;
        txn[1]  = '0;
        set_p(0, 0, 0, 0, 0);
        do_reset(3);

        // lone imem traffic with an immediate bus
        set_p(100, 0, 100, 100, 100);
        run(8);
        // contention, bus always ready
        set_p(100, 100, 100, 100, 100);
        run(20);
        // bus stalls grants: selection must stay pinned
        set_p(0, 100, 0, 100, 100);
        run(2);
        set_p(100, 100, 0, 100, 100);
        run(3);
        set_p(100, 100, 30, 100, 100);
        run(20);
        // no responses: FIFO fills and issue must stop
        set_p(100, 100, 100, 0, 100);
        run(6);
        set_p(100, 100, 100, 100, 100);
        run(6);
        // responses held back by requesters (head-of-line)
        set_p(100, 100, 100, 100, 20);
        run(30);

        for (int blk = 0; blk < 20; blk++) begin
            set_p($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(20, 100),
                  $urandom_range(20, 100), $urandom_range(20, 100));
            run(100);
        end

        // drain, then a response with nothing outstanding
        set_p(0, 0, 100, 100, 100);
        run(20);
        want_spur = 1;
        run(5);
        chk("spur_issued", want_spur, 0);

        // reset with two transactions outstanding
        set_p(100, 100, 100, 0, 100);
        for (int i = 0; i < 50 && exp_q.size() < 2; i++) run(1);
        chk("fill_to_two", exp_q.size(), 2);
        do_reset(1);
        set_p(100, 100, 100, 100, 100);
        run(10);

        for (int blk = 0; blk < 3; blk++) begin
            set_p($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(20, 100),
                  $urandom_range(20, 100), $urandom_range(20, 100));
            run(100);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
